// File: rtl/aes_output_buffer.sv
// Output-side buffer for the AES core: queues 128-bit cipher results and
// streams each one out as four 32-bit words, most-significant word first.
module aes_output_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     done_i,
  input  logic [127:0]             text_i,
  input  logic                     ready_i,
  input  logic                     ovf_clr,
  output logic                     valid_o,
  output logic [31:0]              data_o,
  output logic                     last_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("aes_output_buffer: DEPTH must be a power of two and >= 2");
    end
  endgenerate

  // widx is the only state machine: it walks the head block word by word
  // widx | meaning
  // W0   | word 0 ([127:96]) presented
  // W1   | word 1 ([95:64]) presented
  // W2   | word 2 ([63:32]) presented
  // W3   | word 3 ([31:0]) presented, transfer pops the block
  typedef enum logic [1:0] {W0 = 2'd0, W1 = 2'd1, W2 = 2'd2, W3 = 2'd3} widx_e;

  widx_e           r_widx;
  widx_e           w_widx_nxt;
  logic [127:0]    r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf;

  logic            w_empty;
  logic            w_full;
  logic            w_valid;
  logic            w_xfer;
  logic            w_pop;
  logic            w_wr;
  logic            w_drop;
  logic [127:0]    w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_FULL);
  assign w_valid = !w_empty;
  assign w_xfer  = w_valid && ready_i;
  assign w_pop   = w_xfer && (r_widx == W3);
  // A pop in the same cycle frees the slot, so a full buffer can still accept
  assign w_wr    = done_i && (!w_full || w_pop);
  assign w_drop  = done_i && w_full && !w_pop;
  assign w_head  = r_mem[r_rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_widx <= W0;
    end else begin
      r_widx <= w_widx_nxt;
    end
  end

  always_comb begin
    w_widx_nxt = r_widx;
    if (w_xfer) begin
      case (r_widx)
        W0:      w_widx_nxt = W1;
        W1:      w_widx_nxt = W2;
        W2:      w_widx_nxt = W3;
        default: w_widx_nxt = W0;
      endcase
    end
  end

  always_comb begin
    valid_o = w_valid;
    last_o  = w_valid && (r_widx == W3);
    data_o  = '0;
    if (w_valid) begin
      case (r_widx)
        W0:      data_o = w_head[127:96];
        W1:      data_o = w_head[95:64];
        W2:      data_o = w_head[63:32];
        default: data_o = w_head[31:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= text_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_wr && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_wr) begin
        r_count <= r_count - 1'b1;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign full_o  = w_full;
  assign empty_o = w_empty;
  assign count_o = r_count;
  assign ovf_o   = r_ovf;

endmodule
